// File: rtl/nanorv32_mul_iter.sv
// ---------------------------------------------------------------------------
// nanorv32_mul_iter
//
// Iterative radix-2 shift-add multiplier for the RV32M multiply group
// (MUL, MULH, MULHSU, MULHU). Operands are reduced to magnitudes at
// acceptance, multiplied unsigned over DATA_W fixed steps, and the product
// is sign-corrected once at the end. Latency is fixed: a request accepted on
// the edge ending cycle 0 produces resp_valid in cycle DATA_W+1.
//
// Ports
//   clk          system clock, all state on its rising edge
//   rst          synchronous active-high reset, overrides everything
//   kill         abort any operation in progress (back to IDLE next cycle)
//   req_valid    request present
//   req_ready    block idle and able to accept a request
//   req_op       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_a        operand A (rs1)
//   req_b        operand B (rs2)
//   resp_valid   result present (DONE state)
//   resp_ready   consumer takes the result
//   resp_result  result word, held stable until taken
// ---------------------------------------------------------------------------
module nanorv32_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result
);

  localparam int                  CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0]   ONE_W    = DATA_W'(1);
  localparam logic [2*DATA_W-1:0] ONE_2W   = (2*DATA_W)'(1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Architectural state
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mcand_q;   // |A|, added into the upper half
  logic [2*DATA_W-1:0] acc_q;     // {partial product, remaining multiplier}
  logic                neg_q;
  logic [1:0]          op_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   result_q;

  // Combinational helpers
  logic                sign_a_d;
  logic                sign_b_d;
  logic [DATA_W-1:0]   mag_a_d;
  logic [DATA_W-1:0]   mag_b_d;
  logic [DATA_W:0]     acc_sum_d;
  logic [2*DATA_W-1:0] acc_step_d;
  logic [2*DATA_W-1:0] prod_fix_d;
  logic [DATA_W-1:0]   result_d;

  // Operand conditioning at the acceptance edge. A is signed for MULH and
  // MULHSU, B only for MULH. The most negative value negates to itself,
  // which read as unsigned is exactly its magnitude 2^(DATA_W-1).
  always_comb begin
    sign_a_d = 1'b0;
    sign_b_d = 1'b0;
    if ((req_op == OP_MULH) || (req_op == OP_MULHSU)) begin
      sign_a_d = req_a[DATA_W-1];
    end
    if (req_op == OP_MULH) begin
      sign_b_d = req_b[DATA_W-1];
    end
    mag_a_d = sign_a_d ? ((~req_a) + ONE_W) : req_a;
    mag_b_d = sign_b_d ? ((~req_b) + ONE_W) : req_b;
  end

  // One shift-add step: the multiplier sits in the low half and is consumed
  // LSB first; the carry out of the upper-half add shifts in at the top.
  always_comb begin
    acc_sum_d  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
               + (acc_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
    acc_step_d = {acc_sum_d, acc_q[DATA_W-1:1]};
  end

  // Sign correction and word select for the final step's product. A zero
  // product negates to zero, so neg needs no special case.
  always_comb begin
    prod_fix_d = neg_q ? ((~acc_step_d) + ONE_2W) : acc_step_d;
    if (op_q == OP_MUL) begin
      result_d = prod_fix_d[DATA_W-1:0];
    end else begin
      result_d = prod_fix_d[2*DATA_W-1:DATA_W];
    end
  end

  // Control FSM with registered handshake outputs. rst beats kill, kill
  // beats every handshake input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      op_q         <= OP_MUL;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else if (kill) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_BUSY;
            cnt_q       <= '0;
            mcand_q     <= mag_a_d;
            acc_q       <= {{DATA_W{1'b0}}, mag_b_d};
            neg_q       <= sign_a_d ^ sign_b_d;
            op_q        <= req_op;
            req_ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          acc_q <= acc_step_d;
          cnt_q <= cnt_q + CNT_ONE;
          // Always DATA_W steps; no early-out on small multipliers.
          if (cnt_q == CNT_LAST) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            result_q     <= result_d;
          end
        end
        ST_DONE: begin
          // Leaving DONE lands in IDLE; acceptance waits for the next edge.
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;

endmodule

// File: doc/nanorv32_mul_iter.md
NANORV32_MUL_ITER -- requirements
Module: nanorv32_mul_iter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 The block SHALL have port kill  input  1  abort of any operation in progress.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block able to accept a request.
REQ-007 The block SHALL have port req_op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-008 The block SHALL have port req_a  input  DATA_W  operand A (rs1).
REQ-009 The block SHALL have port req_b  input  DATA_W  operand B (rs2).
REQ-010 The block SHALL have port resp_valid  output  1  result present.
REQ-011 The block SHALL have port resp_ready  input  1  consumer takes result.
REQ-012 The block SHALL have port resp_result  output  DATA_W  result word.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 req_ready SHALL be 1 only in IDLE and 0 in BUSY and DONE.
REQ-015 resp_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on an edge where state is IDLE, req_valid=1 and kill=0; state goes to BUSY and the iteration counter clears to 0.
REQ-017 At acceptance the block SHALL latch |A| and |B|, treating A as signed for MULH/MULHSU and B as signed for MULH only, and SHALL latch neg = signA XOR signB together with the op.
REQ-018 Magnitude SHALL be computed as two's-complement negation when the sign bit is set; 0x80000000 SHALL yield unsigned 2^31.
REQ-019 MUL SHALL treat both operands as unsigned; low-word results are sign-independent.
REQ-020 Each BUSY cycle SHALL perform one radix-2 shift-add step on a 2*DATA_W accumulator: add the multiplicand to the upper half when the multiplier LSB is 1, then shift right by 1.
REQ-021 After DATA_W BUSY steps (counter reaching DATA_W-1), state SHALL go to DONE.
REQ-022 Latency SHALL be fixed: with acceptance at the end of cycle 0, BUSY SHALL cover cycles 1..DATA_W and resp_valid SHALL first be 1 in cycle DATA_W+1 (cycle 33 for DATA_W=32), with no data-dependent early-out.
REQ-023 In DONE, the 2*DATA_W product SHALL be negated when neg=1.
REQ-024 resp_result SHALL be the low word for MUL and the high word for MULH, MULHSU and MULHU.
REQ-025 resp_result SHALL remain stable while resp_valid=1 and resp_ready=0, for any number of cycles.
REQ-026 DONE with resp_ready=1 SHALL return to IDLE on that edge; a new request SHALL NOT be accepted on the same edge, giving a minimum of one IDLE cycle between operations.
REQ-027 kill=1 on any edge SHALL force IDLE and drop resp_valid in the next cycle, discarding partial results.
REQ-028 When kill and req_valid are both 1 in IDLE, kill SHALL take priority and no acceptance SHALL occur.
REQ-029 req_a, req_b and req_op SHALL be ignored outside the acceptance edge.
REQ-030 A zero operand SHALL produce a zero result, including when neg=1.

Reset
REQ-031 rst=1 on an edge SHALL force state IDLE, counter 0, accumulator 0 and neg 0.
REQ-032 rst=1 SHALL give req_ready=1, resp_valid=0 and resp_result=0 in the following cycle.
REQ-033 rst SHALL override kill and all handshake inputs.
REQ-034 rst asserted mid-BUSY or in DONE SHALL discard the operation with no resp_valid pulse.

Verification
REQ-035 Bench SHALL cover: MULH A=0x80000000, B=0x80000000 -> resp_result 0x40000000, resp_valid first high in cycle 33.
REQ-036 Bench SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-037 Bench SHALL cover: MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF; MULH A=0xFFFFFFFF, B=0x00000001 -> 0xFFFFFFFF.
REQ-038 Bench SHALL cover: resp_ready held 0 for 10 cycles in DONE -> resp_valid and resp_result constant; resp_ready=1 -> req_ready=1 in the next cycle.
REQ-039 Bench SHALL cover: kill in BUSY cycle 5 -> IDLE next cycle, no resp_valid; a following MUL 7 x 6 -> 42.
REQ-040 Bench SHALL cover: rst in BUSY cycle 20 -> req_ready=1, resp_valid=0 and resp_result=0 next cycle; a following MUL 3 x 5 -> 15 at cycle 33.
